// File: rtl/debug_slave_pkg.sv
// Shared defaults, command entry layout and IR code names for the
// system-clock side of the JTAG debug slave.
package debug_slave_pkg;

    localparam int DEFAULT_IR_W    = 2;
    localparam int DEFAULT_DR_W    = 38;
    localparam int DEFAULT_ACT_BIT = 37;

    // One captured update-DR: the instruction and its shifted data word.
    typedef struct packed {
        logic [DEFAULT_IR_W-1:0] ir;
        logic [DEFAULT_DR_W-1:0] data;
    } cmd_entry_t;

    localparam logic [DEFAULT_IR_W-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [DEFAULT_IR_W-1:0] IR_TRACEDATA = 2'd1;
    localparam logic [DEFAULT_IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [DEFAULT_IR_W-1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/debug_slave_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, followed by a rising-edge
// detector. All flops reset to 1 so a level that is already high when reset
// releases is not mistaken for a new edge.
module debug_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous level through the synchroniser and keep one
    // cycle of history of the synchronised value.
    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// System-clock half of the JTAG debug slave: synchronises update-DR/IR,
// queues captured {ir, data} commands and, per dequeue, presents a held jdo
// word with a one-cycle one-hot action / no-action pulse.
module debug_slave_cmd_queue
    import debug_slave_pkg::*;
#(
    parameter int IR_W        = DEFAULT_IR_W,
    parameter int DR_W        = DEFAULT_DR_W,
    parameter int ACT_BIT     = DEFAULT_ACT_BIT,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NUM_CMD    = 2 ** IR_W,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vs_udr,
    input  logic               vs_uir,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [DR_W-1:0]    sr,
    output logic               cmd_valid,
    output logic [IR_W-1:0]    cmd_ir,
    input  logic               cmd_ready,
    output logic [DR_W-1:0]    jdo,
    output logic [NUM_CMD-1:0] take_action,
    output logic [NUM_CMD-1:0] take_no_action,
    output logic               ir_update,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } entry_t;

    logic rise_udr;
    logic rise_uir;

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_udr),
        .rise_o  (rise_udr)
    );

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (vs_uir),
        .rise_o  (rise_uir)
    );

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [DR_W-1:0]    jdo_q, jdo_d;
    logic [NUM_CMD-1:0] act_q, act_d;
    logic [NUM_CMD-1:0] noact_q, noact_d;
    logic               ir_update_q;

    entry_t             head;
    logic [NUM_CMD-1:0] head_onehot;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign head        = mem_q[rd_ptr_q];
    assign head_onehot = NUM_CMD'(1) << head.ir;
    assign empty       = (level_q == '0);
    assign full        = (level_q == LVL_W'(DEPTH));
    assign pop         = ~empty & cmd_ready;
    // A pop in the same cycle frees the head slot, so a full queue still
    // accepts the new entry.
    assign push_ok     = rise_udr & (~full | pop);

    // Next-state for pointers, occupancy, sticky overflow and pop outputs.
    // NOTE: every variable gets its default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        jdo_d      = jdo_q;
        act_d      = '0;
        noact_d    = '0;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            jdo_d    = head.data;
            if (head.data[ACT_BIT]) begin
                act_d = head_onehot;
            end else begin
                noact_d = head_onehot;
            end
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A dropped entry outranks a simultaneous clear.
        if (rise_udr && !push_ok) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control and output registers; reset discards the queue and aborts pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            jdo_q       <= '0;
            act_q       <= '0;
            noact_q     <= '0;
            ir_update_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            jdo_q       <= jdo_d;
            act_q       <= act_d;
            noact_q     <= noact_d;
            ir_update_q <= rise_uir;
        end
    end

    // Command storage, written at the tail on each accepted update-DR.
    // NOTE: storage has no reset; level gates every read, so stale contents
    // are never observed and the array can map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{ir: ir_in, data: sr};
        end
    end

    assign cmd_valid      = ~empty;
    assign cmd_ir         = head.ir;
    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign ir_update      = ir_update_q;
    assign level          = level_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Scoreboard bench for debug_slave_cmd_queue: a queue-based reference model
// predicts dequeued commands; a negedge monitor compares every DUT output.
module tb_debug_slave_cmd_queue;
    import debug_slave_pkg::*;

    localparam int IR_W    = DEFAULT_IR_W;
    localparam int DR_W    = DEFAULT_DR_W;
    localparam int ACT_BIT = DEFAULT_ACT_BIT;
    localparam int DEPTH   = 4;
    localparam int SYNC    = 2;
    localparam int NUM_CMD = 2 ** IR_W;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               vs_udr;
    logic               vs_uir;
    logic [IR_W-1:0]    ir_in;
    logic [DR_W-1:0]    sr;
    logic               cmd_valid;
    logic [IR_W-1:0]    cmd_ir;
    logic               cmd_ready;
    logic [DR_W-1:0]    jdo;
    logic [NUM_CMD-1:0] take_action;
    logic [NUM_CMD-1:0] take_no_action;
    logic               ir_update;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               clr_overflow;

    int checks   = 0;
    int failures = 0;

    debug_slave_cmd_queue #(
        .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT_BIT),
        .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .cmd_ready      (cmd_ready),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .level          (level),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Strobes are seen as ideal samples delayed by the synchroniser depth;
    // a 0->1 step in the delayed sample stream is one push / one IR update.
    cmd_entry_t      model_q[$];
    cmd_entry_t      exp_q[$];
    logic [7:0]      udr_hist;
    logic [7:0]      uir_hist;
    logic            m_ovf;
    logic            m_iru;
    logic [DR_W-1:0] m_jdo;
    bit              m_pop;
    bit              m_push;
    cmd_entry_t      m_ent;

    // Advance the model one clock: pop if consumer ready, then push or drop.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_q.delete();
            exp_q.delete();
            udr_hist = '1;
            uir_hist = '1;
            m_ovf    = 1'b0;
            m_iru    = 1'b0;
            m_jdo    = '0;
        end else begin
            m_pop  = (model_q.size() > 0) && cmd_ready;
            m_push = udr_hist[SYNC-1] && !udr_hist[SYNC];
            m_iru  = uir_hist[SYNC-1] && !uir_hist[SYNC];
            if (m_pop) begin
                m_ent = model_q.pop_front();
                exp_q.push_back(m_ent);
                m_jdo = m_ent.data;
            end
            if (m_push && model_q.size() >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                if (m_push) model_q.push_back('{ir: ir_in, data: sr});
                if (clr_overflow) m_ovf = 1'b0;
            end
            udr_hist = {udr_hist[6:0], vs_udr};
            uir_hist = {uir_hist[6:0], vs_uir};
        end
    end

    // ---------------- monitor ----------------
    cmd_entry_t         mon_ent;
    logic [NUM_CMD-1:0] mon_one;
    logic [NUM_CMD-1:0] mon_exp;

    // Compare observable state every cycle and consume one expected command
    // whenever the DUT presents a pulse.
    always @(negedge clk) begin
        check("level", 64'(level), 64'(model_q.size()));
        check("cmd_valid", 64'(cmd_valid), 64'(model_q.size() != 0));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("ir_update", 64'(ir_update), 64'(m_iru));
        check("jdo_hold", 64'(jdo), 64'(m_jdo));
        if (model_q.size() != 0) check("cmd_ir", 64'(cmd_ir), 64'(model_q[0].ir));
        if ((take_action | take_no_action) != '0) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", 64'({take_action, take_no_action}), 64'(0));
            end else begin
                mon_ent = exp_q.pop_front();
                mon_one = 1;
                mon_exp = mon_one << mon_ent.ir;
                check("take_action", 64'(take_action), mon_ent.data[ACT_BIT] ? 64'(mon_exp) : 64'(0));
                check("take_no_action", 64'(take_no_action), mon_ent.data[ACT_BIT] ? 64'(0) : 64'(mon_exp));
                check("pulse_jdo", 64'(jdo), 64'(mon_ent.data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_mode = 1'b0;

    task automatic rand_side();
        if (rnd_mode) begin
            cmd_ready    = 1'($urandom_range(0, 1));
            clr_overflow = ($urandom_range(0, 7) == 0);
            vs_uir       = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One update-DR: data held from the rising strobe until the next event.
    task automatic udr_event(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data,
                             input int high, input int low);
        @(negedge clk);
        ir_in = ir; sr = data; vs_udr = 1'b1; rand_side();
        for (int i = 1; i < high; i++) begin @(negedge clk); rand_side(); end
        @(negedge clk);
        vs_udr = 1'b0; rand_side();
        for (int i = 1; i < low; i++) begin @(negedge clk); rand_side(); end
    endtask

    // Single command with the consumer ready: checks latency and pulse.
    task automatic single_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data,
                              input logic [NUM_CMD-1:0] exp_act, input logic [NUM_CMD-1:0] exp_noact);
        @(negedge clk);
        cmd_ready = 1'b1; ir_in = ir; sr = data; vs_udr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("valid_before_latency", 64'(cmd_valid), 64'(0));
        @(posedge clk); #1;
        check("valid_at_latency", 64'(cmd_valid), 64'(1));
        check("cmd_ir_head", 64'(cmd_ir), 64'(ir));
        @(negedge clk);
        vs_udr = 1'b0;
        @(posedge clk); #1;
        check("single_take_action", 64'(take_action), 64'(exp_act));
        check("single_take_no_action", 64'(take_no_action), 64'(exp_noact));
        check("single_jdo", 64'(jdo), 64'(data));
        @(posedge clk); #1;
        check("single_pulse_end", 64'({take_action, take_no_action}), 64'(0));
        check("single_jdo_held", 64'(jdo), 64'(data));
    endtask

    logic [63:0] r64;

    initial begin
        reset_n = 1'b1; vs_udr = 1'b1; vs_uir = 1'b1;
        ir_in = '0; sr = '0; cmd_ready = 1'b0; clr_overflow = 1'b0;
        #1 reset_n = 1'b0;

        // Reset released with both strobes already high: no push, no update.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_level", 64'(level), 64'(0));
        check("rst_ir_update", 64'(ir_update), 64'(0));
        check("rst_take", 64'({take_action, take_no_action}), 64'(0));
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (3) @(negedge clk);

        // Action and no-action single commands.
        single_cmd(IR_BREAK, 38'h20_0000_0005, 4'b0100, 4'b0000);
        single_cmd(IR_OCIMEM, 38'h00_0000_0005, 4'b0000, 4'b0001);

        // Overfill with consumer stalled, then burst drain.
        @(negedge clk); cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r64 = {$urandom(), $urandom()};
            udr_event(IR_W'(i % NUM_CMD), r64[DR_W-1:0], 2, 3);
        end
        check("fill_level", 64'(level), 64'(DEPTH));
        check("fill_overflow", 64'(overflow), 64'(1));
        cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            check("burst_pulse", 64'(take_action | take_no_action), 64'(1 << i));
        end
        @(posedge clk); #1;
        check("burst_end", 64'({take_action, take_no_action}), 64'(0));
        check("burst_level", 64'(level), 64'(0));

        // Full queue with push and pop on the same edge.
        @(negedge clk); cmd_ready = 1'b0; clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        check("clr_before_full", 64'(overflow), 64'(0));
        for (int i = 0; i < DEPTH; i++) udr_event(IR_TRACEDATA, DR_W'(i + 16), 2, 3);
        check("full_level", 64'(level), 64'(DEPTH));
        @(negedge clk); ir_in = IR_TRACECTRL; sr = 38'h3F_1234_5678; vs_udr = 1'b1;
        @(negedge clk);
        @(negedge clk); cmd_ready = 1'b1;
        @(negedge clk); cmd_ready = 1'b0; vs_udr = 1'b0;
        check("full_pushpop_level", 64'(level), 64'(DEPTH));
        check("full_pushpop_overflow", 64'(overflow), 64'(0));
        udr_event(IR_BREAK, 38'h1, 2, 3);
        check("drop_overflow", 64'(overflow), 64'(1));
        check("drop_level", 64'(level), 64'(DEPTH));
        clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        check("clr_overflow", 64'(overflow), 64'(0));
        cmd_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        check("drain_level", 64'(level), 64'(0));

        // IR update pulse latency and width.
        @(negedge clk); vs_uir = 1'b1;
        @(posedge clk); #1; check("iru_e1", 64'(ir_update), 64'(0));
        @(posedge clk); #1; check("iru_e2", 64'(ir_update), 64'(0));
        @(posedge clk); #1; check("iru_e3", 64'(ir_update), 64'(1));
        @(negedge clk); vs_uir = 1'b0;
        @(posedge clk); #1; check("iru_e4", 64'(ir_update), 64'(0));

        // Reset with two entries queued.
        @(negedge clk); cmd_ready = 1'b0;
        udr_event(IR_TRACEDATA, 38'h20_AAAA_0001, 2, 3);
        udr_event(IR_BREAK, 38'h00_5555_0002, 2, 3);
        check("pre_reset_level", 64'(level), 64'(2));
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(cmd_valid), 64'(0));
        check("rst_mid_level", 64'(level), 64'(0));
        check("rst_mid_jdo", 64'(jdo), 64'(0));
        check("rst_mid_take", 64'({take_action, take_no_action}), 64'(0));
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_level", 64'(level), 64'(0));

        // Randomised traffic, checked by the monitor against the model.
        rnd_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r64 = {$urandom(), $urandom()};
            udr_event(IR_W'($urandom_range(0, NUM_CMD - 1)), r64[DR_W-1:0],
                      $urandom_range(1, 4), $urandom_range(2, 4));
        end
        rnd_mode = 1'b0;
        @(negedge clk); cmd_ready = 1'b1; clr_overflow = 1'b0; vs_uir = 1'b0;
        repeat (DEPTH + 6) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/debug_slave_cmd_queue.md
Name: debug_slave_cmd_queue

Overview:
- System-clock half of the JTAG debug slave, generalised from the fixed 2-bit-IR, 38-bit-DR Nios II debug slave sysclk stage.
- Synchronises the TCK-domain update-DR and update-IR strobes into clk, and captures the quasi-static {ir_in, sr} pair on each update-DR.
- Buffers captured commands in a small FIFO so the CPU-side debug logic can stall.
- On each dequeue, emits a registered jdo word plus a one-hot take_action / take_no_action pulse per IR code.

Parameters:
- IR_W, 2, width of virtual-JTAG instruction register; NUM_CMD = 2**IR_W.
- DR_W, 38, width of the data shift register and jdo.
- ACT_BIT, 37, bit of captured DR selecting action (1) vs no-action (0).
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2, synchroniser flops per strobe; at least 2.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- vs_udr, in, 1, update-DR level from the TCK domain; asynchronous to clk.
- vs_uir, in, 1, update-IR level from the TCK domain; asynchronous to clk.
- ir_in, in, IR_W, instruction register; stable while vs_udr is high.
- sr, in, DR_W, data shift register; stable while vs_udr is high.
- cmd_valid, out, 1, FIFO not empty.
- cmd_ir, out, IR_W, IR field of the FIFO head (first-word fall-through).
- cmd_ready, in, 1, consumer accepts the head entry.
- jdo, out, DR_W, data of the last dequeued entry; held between pops.
- take_action, out, NUM_CMD, one-cycle pulse; bit = ir of the popped entry, when that entry's data[ACT_BIT]=1.
- take_no_action, out, NUM_CMD, same pulse when data[ACT_BIT]=0.
- ir_update, out, 1, one-cycle pulse per synchronised vs_uir rising edge.
- level, out, $clog2(DEPTH)+1, FIFO occupancy.
- overflow, out, 1, sticky: an update-DR was dropped because the FIFO was full.
- clr_overflow, in, 1, synchronous clear of overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - Synchroniser stages and edge-detect history flops reset to 1. This prevents a spurious edge at reset release, whatever the vs_udr / vs_uir level.
  - level=0, cmd_valid=0, jdo=0, take_action=0, take_no_action=0, ir_update=0, overflow=0.
- Synchronisation: each strobe passes through SYNC_STAGES flops; rise = synced & ~prev.
- Push on rise_udr: write {ir_in, sr}. Latency: cmd_valid rises SYNC_STAGES+1 clk edges after the first edge that samples vs_udr high.
- ir_update: registered pulse, same latency, from vs_uir.
- Pop: occurs when cmd_valid & cmd_ready. cmd_ir shows the head combinationally from FIFO storage.
- On the edge after a pop:
  - jdo is loaded with the popped data.
  - Exactly one bit of take_action or take_no_action is high for one cycle, both selected by the popped entry.
- Back-to-back pops give pulses on consecutive cycles. jdo updates every pop.
- Full FIFO and push without pop: entry dropped, overflow set, level unchanged.
- Full FIFO with push and pop in the same cycle: both occur, no overflow, level stays DEPTH.
- Empty FIFO: cmd_ready ignored, no pulse, jdo held.
- Push and pop in the same cycle when not full: level unchanged.
- Pointers: log2(DEPTH) bits, natural wrap. level is a separate counter; empty and full are derived from level.
- overflow set and clr_overflow in the same cycle: set wins.
- Reset mid-operation: all queued entries discarded; pulses abort immediately.
- Each vs_udr high period yields one push at most, even if it lasts many clk cycles.

Decomposition:
- Package debug_slave_pkg holds:
  - IR_W and DR_W defaults.
  - Typedef cmd_entry_t = packed {ir, data}.
  - IR code constants: IR_OCIMEM=0, IR_TRACEDATA=1, IR_BREAK=2, IR_TRACECTRL=3.
- Sub-module debug_slave_sync_edge (parameter SYNC_STAGES, reset-to-1 stages, rise output), instantiated for vs_udr and vs_uir.
- FIFO storage is inline in this block.

Test Plan:
- Reset released with vs_udr held high for 10 cycles -> no push; level=0, ir_update=0.
- ir_in=2, sr=38'h20_0000_0005, vs_udr pulsed for 3 clk, cmd_ready=1 -> cmd_valid high at edge 3; next edge take_action=4'b0100 for 1 cycle; jdo=38'h20_0000_0005.
- Same stimulus with sr[37]=0, ir_in=0 -> take_no_action=4'b0001; take_action stays 0.
- cmd_ready=0, 5 update-DR events with ir 0,1,2,3,0 -> level=4, overflow=1. Then cmd_ready=1 -> pulses on bits 0,1,2,3 on 4 consecutive cycles; level reaches 0.
- FIFO full, with an update-DR push aligned to a cycle where cmd_ready=1 -> level stays 4, overflow unchanged. clr_overflow -> overflow=0.
- vs_uir pulse -> ir_update high exactly 1 cycle, 3 edges after sampling. Assert reset_n low with 2 entries queued -> outputs zero immediately; after release, level=0.
